// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_pkg
// Purpose  : Shared types and constants for the forwarding scoreboard. It holds
//            the slot record, the hardwired-zero register address and the
//            default core widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fwd_scoreboard_pkg;

  localparam int CORE_DW = 32;
  localparam int CORE_AW = 5;
  localparam int CORE_TW = 2;

  // Register 0 always reads as zero, so it can never be a forwarding target.
  localparam logic [CORE_AW-1:0] REG_ZERO = '0;

  // One tracked in-flight write. The record is sized by the core widths, so
  // an AW/TW override on the scoreboard must be matched here.
  typedef struct packed {
    logic               valid;
    logic [CORE_AW-1:0] dst;
    logic [CORE_TW-1:0] tnew;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_if
// Purpose  : Bundles the issue, pipeline-control, stage-data and read-port
//            signals of the forwarding scoreboard.
// Ports    : master - pipeline side (drives issue/read requests, receives
//                     forwarded operands and stall)
//            slave  - scoreboard side
// Revision : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW     = CORE_DW,
  parameter int AW     = CORE_AW,
  parameter int NSTAGE = 3,
  parameter int NREAD  = 2,
  parameter int TW     = CORE_TW
) ();

  logic                    issue_valid;
  logic [AW-1:0]           issue_dst;
  logic [TW-1:0]           issue_tnew;
  logic                    flush;
  logic                    freeze;
  logic [NSTAGE*DW-1:0]    stage_data;
  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD*TW-1:0]     rd_tuse;
  logic [NREAD*DW-1:0]     rf_data;
  logic [NREAD*DW-1:0]     fwd_data;
  logic [NREAD-1:0]        fwd_hit;
  logic                    stall;

  modport master (
    output issue_valid, issue_dst, issue_tnew, flush, freeze,
    output stage_data, rd_addr, rd_tuse, rf_data,
    input  fwd_data, fwd_hit, stall
  );

  modport slave (
    input  issue_valid, issue_dst, issue_tnew, flush, freeze,
    input  stage_data, rd_addr, rd_tuse, rf_data,
    output fwd_data, fwd_hit, stall
  );

endinterface
`default_nettype wire

// File: rtl/fwd_port_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_port_sel
// Purpose  : Youngest-match priority search for one decode read port.
// Ports    : slots   in  tracked slot records, index 0 = youngest (E)
//            rd_addr in  register address read by this port
//            hit     out some valid slot writes rd_addr (never for reg 0)
//            sel     out index of the youngest matching slot
//            tnew    out remaining cycles of that slot's result
// Revision : 1.0 - initial release
// ============================================================================
module fwd_port_sel
  import fwd_scoreboard_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int AW     = CORE_AW,
  parameter int TW     = CORE_TW,
  parameter int SELW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  slot_t [NSTAGE-1:0] slots,
  input  logic  [AW-1:0]     rd_addr,
  output logic               hit,
  output logic  [SELW-1:0]   sel,
  output logic  [TW-1:0]     tnew
);

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    tnew = '0;
    // Walk from oldest to youngest so a younger match overwrites an older one.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].dst == rd_addr) && (rd_addr != REG_ZERO)) begin
        hit  = 1'b1;
        sel  = SELW'(k);
        tnew = slots[k].tnew;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Tracks in-flight register writes across NSTAGE post-decode
//            stages and produces forwarded operands plus the decode stall.
// Ports    : clk    in  clock
//            reset  in  asynchronous active-high reset, drops all slots
//            bus    slave modport of fwd_scoreboard_if:
//                     issue_* / flush / freeze  - slot 0 insertion control
//                     stage_data                - per-slot result lanes
//                     rd_addr / rd_tuse / rf_data - decode read ports
//                     fwd_data / fwd_hit / stall - forwarding results
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW     = CORE_DW,
  parameter int AW     = CORE_AW,
  parameter int NSTAGE = 3,
  parameter int NREAD  = 2,
  parameter int TW     = CORE_TW
) (
  input  logic              clk,
  input  logic              reset,
  fwd_scoreboard_if.slave   bus
);

  localparam int            SELW     = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [TW-1:0] TNEW_ONE = TW'(1);

  slot_t [NSTAGE-1:0]          slot_q;
  slot_t [NSTAGE-1:0]          slot_d;
  logic  [NREAD-1:0]           match;
  logic  [NREAD-1:0]           port_stall;
  logic  [NREAD-1:0]           port_hit;
  logic  [NREAD-1:0][SELW-1:0] match_sel;
  logic  [NREAD-1:0][TW-1:0]   match_tnew;
  logic                        stall;

  // ---------------------------------------------------------------------------
  // Per-port match, forward select and stall request
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NREAD; i++) begin : g_port
    fwd_port_sel #(
      .NSTAGE (NSTAGE),
      .AW     (AW),
      .TW     (TW),
      .SELW   (SELW)
    ) u_sel (
      .slots   (slot_q),
      .rd_addr (bus.rd_addr[i*AW +: AW]),
      .hit     (match[i]),
      .sel     (match_sel[i]),
      .tnew    (match_tnew[i])
    );

    // A result still in flight stalls only if it cannot arrive before use.
    assign port_stall[i] = match[i] && (match_tnew[i] > bus.rd_tuse[i*TW +: TW]);
    assign port_hit[i]   = match[i] && (match_tnew[i] == '0);

    assign bus.fwd_hit[i]            = port_hit[i];
    assign bus.fwd_data[i*DW +: DW]  = port_hit[i]
                                     ? bus.stage_data[int'(match_sel[i])*DW +: DW]
                                     : bus.rf_data[i*DW +: DW];
  end

  assign stall     = |port_stall;
  assign bus.stall = stall;

  // ---------------------------------------------------------------------------
  // Slot shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_d = slot_q;
    if (!bus.freeze) begin
      for (int k = 1; k < NSTAGE; k++) begin
        slot_d[k] = slot_q[k-1];
        if (slot_q[k-1].tnew != '0) begin
          slot_d[k].tnew = slot_q[k-1].tnew - TNEW_ONE;
        end
      end
      // Stall and flush both leave a bubble; writes to reg 0 are never tracked.
      slot_d[0] = '0;
      if (bus.issue_valid && (bus.issue_dst != REG_ZERO) && !stall && !bus.flush) begin
        slot_d[0].valid = 1'b1;
        slot_d[0].dst   = bus.issue_dst;
        slot_d[0].tnew  = bus.issue_tnew;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule
`default_nettype wire
